video_layer_mux: RTL and testbench

Parametrised, pipelined video layer compositor that replaces the two-input combinational pixel select between the staff overlay and the camera feed. It takes NUM_LAYERS pixel streams with per-pixel valid (transparency) flags and produces one output pixel in priority, fixed-select or alpha-blend mode. Mode, select and alpha changes take effect only at frame start, so there is no tearing. It sits between the layer generators (camera path, staff renderer, crosshair/threshold overlays) and the HDMI/TMDS encoder, and delays the sync/active signals to match its own latency.

---
 rtl/video_pkg.sv | 23 ++
 rtl/video_layer_mux_if.sv | 35 +++
 rtl/alpha_blend_channel.sv | 37 +++
 rtl/video_layer_mux.sv | 138 +++++++++++++
 tb/tb_video_layer_mux.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared types and helpers for the video layer compositor.
package video_pkg;

    typedef enum logic [1:0] {
        MODE_PRIORITY = 2'd0,
        MODE_SELECT   = 2'd1,
        MODE_BLEND    = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    localparam int          MAX_LAYERS       = 8;
    localparam logic [23:0] BG_COLOR_DEFAULT = 24'h000000;
    localparam logic [3:0]  PRIO_NONE        = 4'd8;

    // Lowest set index wins; PRIO_NONE when no bit is set.
    function automatic logic [3:0] prio_index(input logic [MAX_LAYERS-1:0] valid);
        prio_index = PRIO_NONE;
        for (int i = MAX_LAYERS - 1; i >= 0; i--) begin
            if (valid[i]) prio_index = 4'(i);
        end
    endfunction

endpackage

// File: rtl/video_layer_mux_if.sv
// Pixel/timing bundle between layer generators, compositor and encoder.
interface video_layer_mux_if #(
    parameter int NUM_LAYERS = 4,
    parameter int CH_W       = 8
);
    localparam int PIX_W = 3 * CH_W;
    localparam int SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic [NUM_LAYERS*PIX_W-1:0] layer_pixel_in;
    logic [NUM_LAYERS-1:0]       layer_valid_in;
    logic                        active_in;
    logic                        hsync_in;
    logic                        vsync_in;
    logic [1:0]                  mode_in;
    logic [SEL_W-1:0]            sel_in;
    logic [7:0]                  alpha_in;
    logic [PIX_W-1:0]            pixel_out;
    logic                        active_out;
    logic                        hsync_out;
    logic                        vsync_out;
    logic [1:0]                  mode_cur_out;

    modport master (
        output layer_pixel_in, layer_valid_in, active_in, hsync_in, vsync_in,
               mode_in, sel_in, alpha_in,
        input  pixel_out, active_out, hsync_out, vsync_out, mode_cur_out
    );

    modport slave (
        input  layer_pixel_in, layer_valid_in, active_in, hsync_in, vsync_in,
               mode_in, sel_in, alpha_in,
        output pixel_out, active_out, hsync_out, vsync_out, mode_cur_out
    );

endinterface

// File: rtl/alpha_blend_channel.sv
// One colour channel of the blend datapath: registered products, then sum/shift/blank.
module alpha_blend_channel #(
    parameter int CH_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [8:0]      a_eff_p0,
    input  logic [CH_W-1:0] top_p0,
    input  logic [CH_W-1:0] base_p0,
    input  logic            vld_p1,
    output logic [CH_W-1:0] ch_p2
);
    localparam int          PROD_W = CH_W + 9;
    localparam logic [8:0]  A_FULL = 9'd256;

    logic [PROD_W-1:0] prod_top_p1;
    logic [PROD_W-1:0] prod_base_p1;
    logic [PROD_W-1:0] sum_p1;

    // Stage 2: weighted products
    always_ff @(posedge clk) begin
        prod_top_p1  <= PROD_W'(a_eff_p0) * PROD_W'(top_p0);
        prod_base_p1 <= PROD_W'(A_FULL - a_eff_p0) * PROD_W'(base_p0);
    end

    assign sum_p1 = prod_top_p1 + prod_base_p1;

    // Stage 3: sum, truncate, blank outside the active region
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_p2 <= '0;
        end else begin
            ch_p2 <= vld_p1 ? CH_W'(sum_p1 >> 8) : '0;
        end
    end

endmodule

// File: rtl/video_layer_mux.sv
// Pipelined layer compositor: priority / fixed select / alpha blend, 3-cycle latency.
module video_layer_mux
    import video_pkg::*;
#(
    parameter int                NUM_LAYERS = 4,
    parameter int                CH_W       = 8,
    parameter logic [3*CH_W-1:0] BG_COLOR   = (3*CH_W)'(BG_COLOR_DEFAULT)
) (
    input logic              clk_in,
    input logic              rst_n_in,
    video_layer_mux_if.slave vif
);
    localparam int         PIX_W  = 3 * CH_W;
    localparam int         SEL_W  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [8:0] A_FULL = 9'd256;

    mode_e            mode_cur;
    logic [SEL_W-1:0] sel_cur;
    logic [7:0]       alpha_cur;
    logic             vs_prev;
    logic             vs_rise;

    // Config only moves on a vsync rising edge so a frame never mixes modes.
    assign vs_rise = vif.vsync_in & ~vs_prev;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vs_prev   <= 1'b0;
            mode_cur  <= MODE_PRIORITY;
            sel_cur   <= '0;
            alpha_cur <= 8'd255;
        end else begin
            vs_prev <= vif.vsync_in;
            if (vs_rise) begin
                mode_cur  <= mode_e'(vif.mode_in);
                sel_cur   <= vif.sel_in;
                alpha_cur <= vif.alpha_in;
            end
        end
    end

    logic [PIX_W-1:0] layer_pix [NUM_LAYERS];

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_unpack
        assign layer_pix[g] = vif.layer_pixel_in[g*PIX_W +: PIX_W];
    end

    logic [MAX_LAYERS-1:0] valid_ext;
    logic [3:0]            top_idx;
    logic [3:0]            base_idx;
    logic [PIX_W-1:0]      pri_pix;
    logic [PIX_W-1:0]      base_pix;
    logic [PIX_W-1:0]      sel_pix;
    logic [PIX_W-1:0]      top_s;
    logic [PIX_W-1:0]      base_s;
    logic [8:0]            a_eff_s;

    // Every mode is expressed as a blend so latency is identical:
    // non-blend modes use a_eff = 256 with top == base.
    always_comb begin
        valid_ext = MAX_LAYERS'(vif.layer_valid_in);
        top_idx   = prio_index(valid_ext);
        base_idx  = prio_index(valid_ext & ~MAX_LAYERS'(1));
        pri_pix   = BG_COLOR;
        base_pix  = BG_COLOR;
        sel_pix   = BG_COLOR;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (top_idx == 4'(i))    pri_pix  = layer_pix[i];
            if (base_idx == 4'(i))   base_pix = layer_pix[i];
            if (sel_cur == SEL_W'(i)) sel_pix = layer_pix[i];
        end

        top_s   = pri_pix;
        base_s  = pri_pix;
        a_eff_s = A_FULL;
        case (mode_cur)
            MODE_SELECT: begin
                top_s  = sel_pix;
                base_s = sel_pix;
            end
            MODE_BLEND: begin
                top_s   = layer_pix[0];
                base_s  = base_pix;
                a_eff_s = vif.layer_valid_in[0] ? ({1'b0, alpha_cur} + 9'(alpha_cur[7])) : '0;
            end
            default: ;
        endcase
    end

    logic [PIX_W-1:0] top_p0;
    logic [PIX_W-1:0] base_p0;
    logic [8:0]       a_eff_p0;
    logic             vld_p0, vld_p1, vld_p2;
    logic             hs_p0, hs_p1, hs_p2;
    logic             vs_p0, vs_p1, vs_p2;

    // Stage 1: resolved top/base/weight
    always_ff @(posedge clk_in) begin
        top_p0   <= top_s;
        base_p0  <= base_s;
        a_eff_p0 <= a_eff_s;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            {vld_p0, vld_p1, vld_p2} <= '0;
            {hs_p0, hs_p1, hs_p2}    <= '0;
            {vs_p0, vs_p1, vs_p2}    <= '0;
        end else begin
            {vld_p0, vld_p1, vld_p2} <= {vif.active_in, vld_p0, vld_p1};
            {hs_p0, hs_p1, hs_p2}    <= {vif.hsync_in, hs_p0, hs_p1};
            {vs_p0, vs_p1, vs_p2}    <= {vif.vsync_in, vs_p0, vs_p1};
        end
    end

    logic [PIX_W-1:0] pix_p2;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        alpha_blend_channel #(
            .CH_W (CH_W)
        ) u_ch (
            .clk      (clk_in),
            .rst_n    (rst_n_in),
            .a_eff_p0 (a_eff_p0),
            .top_p0   (top_p0[c*CH_W +: CH_W]),
            .base_p0  (base_p0[c*CH_W +: CH_W]),
            .vld_p1   (vld_p1),
            .ch_p2    (pix_p2[c*CH_W +: CH_W])
        );
    end

    assign vif.pixel_out    = pix_p2;
    assign vif.active_out   = vld_p2;
    assign vif.hsync_out    = hs_p2;
    assign vif.vsync_out    = vs_p2;
    assign vif.mode_cur_out = mode_cur;

endmodule

// File: tb/tb_video_layer_mux.sv
// Directed self-checking bench for video_layer_mux (3 layers, 8-bit channels).
module tb_video_layer_mux;
    localparam int NL = 3;
    localparam int CH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    video_layer_mux_if #(.NUM_LAYERS(NL), .CH_W(CH)) vif ();

    video_layer_mux #(
        .NUM_LAYERS (NL),
        .CH_W       (CH),
        .BG_COLOR   (24'h000000)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .vif      (vif.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic set_layers(input logic [23:0] p0, input logic [23:0] p1,
                              input logic [23:0] p2, input logic [2:0] v);
        vif.layer_pixel_in = {p2, p1, p0};
        vif.layer_valid_in = v;
    endtask

    task automatic reconfig(input logic [1:0] m, input logic [1:0] s, input logic [7:0] a);
        vif.vsync_in = 1'b0;
        step();
        vif.mode_in  = m;
        vif.sel_in   = s;
        vif.alpha_in = a;
        vif.vsync_in = 1'b1;
        step();
        vif.vsync_in = 1'b0;
    endtask

    function automatic logic [23:0] ref_prio(input logic [71:0] p, input logic [2:0] v);
        ref_prio = 24'h000000;
        for (int i = 2; i >= 0; i--) begin
            if (v[i]) ref_prio = p[i*24 +: 24];
        end
    endfunction

    task automatic test_reset();
        #2;
        total++; if (vif.pixel_out !== 24'h0) begin bad++; $display("FAIL rst_pixel: got %h want 000000", vif.pixel_out); end
        total++; if (vif.active_out !== 1'b0) begin bad++; $display("FAIL rst_active: got %b want 0", vif.active_out); end
        total++; if (vif.hsync_out !== 1'b0) begin bad++; $display("FAIL rst_hsync: got %b want 0", vif.hsync_out); end
        total++; if (vif.vsync_out !== 1'b0) begin bad++; $display("FAIL rst_vsync: got %b want 0", vif.vsync_out); end
        total++; if (vif.mode_cur_out !== 2'd0) begin bad++; $display("FAIL rst_mode: got %0d want 0", vif.mode_cur_out); end
        #5;
        rst_n = 1'b1;
    endtask

    task automatic test_priority();
        set_layers(24'hDEADBE, 24'h112233, 24'hFFFFFF, 3'b110);
        vif.active_in = 1'b1;
        steps(2);
        total++; if (vif.pixel_out !== 24'h0) begin bad++; $display("FAIL prio_early: got %h want 000000", vif.pixel_out); end
        step();
        total++; if (vif.pixel_out !== 24'h112233) begin bad++; $display("FAIL prio_l1: got %h want 112233", vif.pixel_out); end
        total++; if (vif.active_out !== 1'b1) begin bad++; $display("FAIL prio_active: got %b want 1", vif.active_out); end
        set_layers(24'hDEADBE, 24'h112233, 24'hFFFFFF, 3'b000);
        steps(3);
        total++; if (vif.pixel_out !== 24'h000000) begin bad++; $display("FAIL prio_bg: got %h want 000000", vif.pixel_out); end
        set_layers(24'hABCDEF, 24'h112233, 24'hFFFFFF, 3'b111);
        steps(3);
        total++; if (vif.pixel_out !== 24'hABCDEF) begin bad++; $display("FAIL prio_l0: got %h want abcdef", vif.pixel_out); end
    endtask

    task automatic test_deferred();
        set_layers(24'hAAAAAA, 24'h112233, 24'h445566, 3'b111);
        vif.mode_in = 2'd1;
        vif.sel_in  = 2'd2;
        steps(4);
        total++; if (vif.pixel_out !== 24'hAAAAAA) begin bad++; $display("FAIL defer_hold: got %h want aaaaaa", vif.pixel_out); end
        total++; if (vif.mode_cur_out !== 2'd0) begin bad++; $display("FAIL defer_mode_old: got %0d want 0", vif.mode_cur_out); end
        vif.vsync_in = 1'b1;
        step();
        total++; if (vif.mode_cur_out !== 2'd1) begin bad++; $display("FAIL defer_mode_new: got %0d want 1", vif.mode_cur_out); end
        step();
        vif.vsync_in = 1'b0;
        step();
        total++; if (vif.pixel_out !== 24'hAAAAAA) begin bad++; $display("FAIL defer_edge_pix: got %h want aaaaaa", vif.pixel_out); end
        step();
        total++; if (vif.pixel_out !== 24'h445566) begin bad++; $display("FAIL defer_sel: got %h want 445566", vif.pixel_out); end
    endtask

    task automatic test_select_oob();
        reconfig(2'd1, 2'd3, 8'd255);
        steps(4);
        total++; if (vif.pixel_out !== 24'h000000) begin bad++; $display("FAIL sel_oob: got %h want 000000", vif.pixel_out); end
        total++; if (vif.mode_cur_out !== 2'd1) begin bad++; $display("FAIL sel_mode: got %0d want 1", vif.mode_cur_out); end
        set_layers(24'hAAAAAA, 24'h112233, 24'h445566, 3'b101);
        reconfig(2'd1, 2'd1, 8'd255);
        steps(4);
        total++; if (vif.pixel_out !== 24'h112233) begin bad++; $display("FAIL sel_invalid_layer: got %h want 112233", vif.pixel_out); end
    endtask

    task automatic test_blend();
        set_layers(24'hFF0000, 24'h0000FF, 24'h123456, 3'b011);
        reconfig(2'd2, 2'd0, 8'd128);
        steps(4);
        total++; if (vif.pixel_out !== 24'h80007E) begin bad++; $display("FAIL blend_128: got %h want 80007e", vif.pixel_out); end
        total++; if (vif.mode_cur_out !== 2'd2) begin bad++; $display("FAIL blend_mode: got %0d want 2", vif.mode_cur_out); end
        reconfig(2'd2, 2'd0, 8'd0);
        steps(4);
        total++; if (vif.pixel_out !== 24'h0000FF) begin bad++; $display("FAIL blend_a0: got %h want 0000ff", vif.pixel_out); end
        reconfig(2'd2, 2'd0, 8'd255);
        steps(4);
        total++; if (vif.pixel_out !== 24'hFF0000) begin bad++; $display("FAIL blend_a255: got %h want ff0000", vif.pixel_out); end
        reconfig(2'd2, 2'd0, 8'd128);
        set_layers(24'hFF0000, 24'h0000FF, 24'h123456, 3'b010);
        steps(4);
        total++; if (vif.pixel_out !== 24'h0000FF) begin bad++; $display("FAIL blend_l0_off: got %h want 0000ff", vif.pixel_out); end
        set_layers(24'hFF0000, 24'h0000FF, 24'h123456, 3'b001);
        steps(3);
        total++; if (vif.pixel_out !== 24'h800000) begin bad++; $display("FAIL blend_bg_base: got %h want 800000", vif.pixel_out); end
        set_layers(24'hFF0000, 24'h0000FF, 24'h123456, 3'b101);
        steps(3);
        total++; if (vif.pixel_out !== 24'h89192A) begin bad++; $display("FAIL blend_l2_base: got %h want 89192a", vif.pixel_out); end
    endtask

    task automatic test_blank_sync();
        logic [71:0] sb_pix [40];
        logic [2:0]  sb_vld [40];
        logic        sb_act [40];
        logic        sb_hs  [40];
        logic        sb_vs  [40];
        logic [23:0] want;
        reconfig(2'd0, 2'd0, 8'd255);
        for (int i = 0; i < 40; i++) begin
            sb_pix[i] = {$urandom(), $urandom(), $urandom()};
            sb_vld[i] = 3'($urandom_range(0, 7));
            sb_act[i] = (i % 10) < 7;
            sb_hs[i]  = (i % 10) == 8;
            sb_vs[i]  = (i >= 20) && (i < 23);
        end
        for (int j = 0; j < 42; j++) begin
            if (j < 40) begin
                vif.layer_pixel_in = sb_pix[j];
                vif.layer_valid_in = sb_vld[j];
                vif.active_in      = sb_act[j];
                vif.hsync_in       = sb_hs[j];
                vif.vsync_in       = sb_vs[j];
            end
            step();
            if (j >= 2) begin
                want = sb_act[j-2] ? ref_prio(sb_pix[j-2], sb_vld[j-2]) : 24'h0;
                total++; if (vif.pixel_out !== want) begin bad++; $display("FAIL blank_pix[%0d]: got %h want %h", j-2, vif.pixel_out, want); end
                total++; if (vif.active_out !== sb_act[j-2]) begin bad++; $display("FAIL sync_active[%0d]: got %b want %b", j-2, vif.active_out, sb_act[j-2]); end
                total++; if (vif.hsync_out !== sb_hs[j-2]) begin bad++; $display("FAIL sync_hs[%0d]: got %b want %b", j-2, vif.hsync_out, sb_hs[j-2]); end
                total++; if (vif.vsync_out !== sb_vs[j-2]) begin bad++; $display("FAIL sync_vs[%0d]: got %b want %b", j-2, vif.vsync_out, sb_vs[j-2]); end
            end
        end
        vif.vsync_in = 1'b0;
        vif.hsync_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_layers(24'hFF0000, 24'h0000FF, 24'h000000, 3'b011);
        vif.active_in = 1'b1;
        vif.hsync_in  = 1'b1;
        reconfig(2'd2, 2'd0, 8'd200);
        steps(4);
        total++; if (vif.pixel_out !== 24'hC80036) begin bad++; $display("FAIL mid_pre_blend: got %h want c80036", vif.pixel_out); end
        total++; if (vif.hsync_out !== 1'b1) begin bad++; $display("FAIL mid_pre_hs: got %b want 1", vif.hsync_out); end
        #3;
        rst_n        = 1'b0;
        vif.mode_in  = 2'd1;
        vif.sel_in   = 2'd2;
        #1;
        total++; if (vif.pixel_out !== 24'h0) begin bad++; $display("FAIL mid_rst_pix: got %h want 000000", vif.pixel_out); end
        total++; if (vif.active_out !== 1'b0) begin bad++; $display("FAIL mid_rst_active: got %b want 0", vif.active_out); end
        total++; if (vif.hsync_out !== 1'b0) begin bad++; $display("FAIL mid_rst_hs: got %b want 0", vif.hsync_out); end
        total++; if (vif.vsync_out !== 1'b0) begin bad++; $display("FAIL mid_rst_vs: got %b want 0", vif.vsync_out); end
        #2;
        rst_n        = 1'b1;
        vif.hsync_in = 1'b0;
        total++; if (vif.mode_cur_out !== 2'd0) begin bad++; $display("FAIL mid_rst_mode: got %0d want 0", vif.mode_cur_out); end
        steps(2);
        total++; if (vif.pixel_out !== 24'h0) begin bad++; $display("FAIL mid_resume_early: got %h want 000000", vif.pixel_out); end
        total++; if (vif.active_out !== 1'b0) begin bad++; $display("FAIL mid_resume_act_early: got %b want 0", vif.active_out); end
        step();
        total++; if (vif.pixel_out !== 24'hFF0000) begin bad++; $display("FAIL mid_resume_pix: got %h want ff0000", vif.pixel_out); end
        total++; if (vif.active_out !== 1'b1) begin bad++; $display("FAIL mid_resume_act: got %b want 1", vif.active_out); end
    endtask

    initial begin
        vif.layer_pixel_in = '0;
        vif.layer_valid_in = '0;
        vif.active_in      = 1'b0;
        vif.hsync_in       = 1'b0;
        vif.vsync_in       = 1'b0;
        vif.mode_in        = 2'd0;
        vif.sel_in         = 2'd0;
        vif.alpha_in       = 8'd255;
        test_reset();
        test_priority();
        test_deferred();
        test_select_oob();
        test_blend();
        test_blank_sync();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
